// File: rtl/ifetch_queue_pkg.sv
// Shared constants and types for the instruction fetch queue.
package ifetch_queue_pkg;

  // Canonical NOP (addi x0, x0, 0) shown on the decode port when idle.
  localparam logic [31:0] IFQ_NOP      = 32'h0000_0013;
  localparam logic [63:0] IFQ_RESET_PC = 64'h0000_0000_8000_0000;

  // Width of the stale-response drop counter; sized well above any
  // number of requests that can be in flight across back-to-back redirects.
  localparam int unsigned IFQ_DROP_W = 8;

  typedef enum logic {
    IF_RUN  = 1'b0,
    IF_HALT = 1'b1
  } ifq_state_e;

endpackage

// File: rtl/ifetch_buf.sv
// In-order fetch buffer: entries are allocated at request time (pc known,
// data pending), filled in order by imem responses, and popped by decode.
module ifetch_buf #(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             alloc,
  input  logic [63:0]      alloc_pc,
  input  logic             fill,
  input  logic [31:0]      fill_data,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] unfilled,
  output logic             head_valid,
  output logic [63:0]      head_pc,
  output logic [31:0]      head_data
);

  logic [63:0]      pc_q     [DEPTH];
  logic [31:0]      data_q   [DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W-1:0] fill_q;

  // Head is presentable only once its response has been written back.
  always_comb begin
    head_valid = (count != '0) && filled_q[head_q];
    head_pc    = pc_q[head_q];
    head_data  = data_q[head_q];
  end

  // Allocate at tail, fill at oldest unfilled, pop at head; flush frees all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        data_q[i] <= '0;
      end
      filled_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      fill_q   <= '0;
      count    <= '0;
      unfilled <= '0;
    end else if (flush) begin
      filled_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      fill_q   <= '0;
      count    <= '0;
      unfilled <= '0;
    end else begin
      if (alloc) begin
        pc_q[tail_q]     <= alloc_pc;
        filled_q[tail_q] <= 1'b0;
        tail_q           <= tail_q + 1'b1;
      end
      if (fill) begin
        data_q[fill_q]   <= fill_data;
        filled_q[fill_q] <= 1'b1;
        fill_q           <= fill_q + 1'b1;
      end
      if (pop) begin
        head_q <= head_q + 1'b1;
      end
      count    <= count + CNT_W'(alloc) - CNT_W'(pop);
      unfilled <= unfilled + CNT_W'(alloc) - CNT_W'(fill);
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: PC, RUN/HALT control, imem request/response
// handling with stale-response dropping after redirects, and decode handshake.
// Optional macro IFETCH_PERF_EN builds the delivered-instruction counter.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = IFQ_RESET_PC,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [63:0] imem_req_addr_o,
  input  logic        imem_resp_valid_i,
  input  logic [31:0] imem_resp_data_i,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i,
  input  logic        halt_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [63:0] pc_o,
  output logic [63:0] perf_fetched_o
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  ifq_state_e            state_q;
  logic [63:0]           pc_q;
  logic [IFQ_DROP_W-1:0] drop_q;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      unfilled;
  logic [CNT_W-1:0]      count_after_pop;
  logic                  head_valid;
  logic [63:0]           head_pc;
  logic [31:0]           head_data;
  logic                  req_fire;
  logic                  pop;
  logic                  resp_drop;
  logic                  resp_fill;

  // Handshake decode; a slot freed by a same-cycle pop may be reallocated.
  always_comb begin
    inst_valid_o     = head_valid && !redirect_i;
    pop              = inst_valid_o && inst_ready_i;
    count_after_pop  = count - CNT_W'(pop);
    imem_req_valid_o = !rst && (state_q == IF_RUN) && !redirect_i &&
                       (count_after_pop < CNT_W'(FIFO_DEPTH));
    imem_req_addr_o  = pc_q;
    req_fire         = imem_req_valid_o && imem_req_ready_i;
    resp_drop        = imem_resp_valid_i && (drop_q != '0);
    resp_fill        = imem_resp_valid_i && (drop_q == '0) && (unfilled != '0);
    inst_o           = inst_valid_o ? head_data : IFQ_NOP;
    pc_o             = inst_valid_o ? head_pc : '0;
  end

  ifetch_buf #(
    .DEPTH (FIFO_DEPTH)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_i),
    .alloc      (req_fire),
    .alloc_pc   (pc_q),
    .fill       (resp_fill),
    .fill_data  (imem_resp_data_i),
    .pop        (pop),
    .count      (count),
    .unfilled   (unfilled),
    .head_valid (head_valid),
    .head_pc    (head_pc),
    .head_data  (head_data)
  );

  // PC, RUN/HALT state and count of responses still owed to flushed entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IF_RUN;
      pc_q    <= RESET_PC;
      drop_q  <= '0;
    end else if (redirect_i) begin
      state_q <= halt_i ? IF_HALT : IF_RUN;
      pc_q    <= {redirect_pc_i[63:2], 2'b00};
      // Entries still waiting on imem become drops; a response landing this
      // cycle (dropped or filling) is already accounted for by subtracting it.
      drop_q  <= drop_q - IFQ_DROP_W'(resp_drop)
               + IFQ_DROP_W'(unfilled) - IFQ_DROP_W'(resp_fill);
    end else begin
      if (halt_i) begin
        state_q <= IF_HALT;
      end
      if (req_fire) begin
        pc_q <= pc_q + 64'd4;
      end
      drop_q <= drop_q - IFQ_DROP_W'(resp_drop);
    end
  end

`ifdef IFETCH_PERF_EN
  logic [63:0] perf_q;

  // Count instructions accepted by decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= '0;
    end else if (pop) begin
      perf_q <= perf_q + 64'd1;
    end
  end

  assign perf_fetched_o = perf_q;
`else
  assign perf_fetched_o = '0;
`endif

endmodule
